// File: rtl/move_command_gen.sv
// Button front end: synchronise, debounce and axis-mask the direction/speed buttons, then
// emit one-cycle move pulses and a wrapping speed step. Define AUTOREPEAT_EN for auto-repeat.
module move_command_gen #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter int MAX_STEP        = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] buttonDir,
  input  logic       buttonSpeed,
  output logic [3:0] moveDirection,
  output logic [3:0] moveStep,
  output logic [1:0] dbg_state_o
);

  localparam logic [19:0] DB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  STEP_MAX = 4'(MAX_STEP);

`ifdef AUTOREPEAT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIRST = 2'd1, S_REPEAT = 2'd2} state_t;
  localparam logic [23:0] DELAY_LAST  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] PERIOD_LAST = 24'(REPEAT_PERIOD - 1);
  logic [23:0] timer_q, timer_d;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1} state_t;
`endif

  // Bit 4 of the input vectors is the speed button, bits 3:0 are {Right, Left, Down, Up}.
  logic [4:0]       sync1_q, sync2_q;
  logic [4:0]       stable_q, stable_d;
  logic [4:0][19:0] cnt_q, cnt_d;
  logic [3:0]       active_q, active_d;
  logic             spd_p1_q, spd_p2_q;
  logic [3:0]       step_q, step_d;
  logic [3:0]       held_q, held_d;
  logic [3:0]       pulse_q, pulse_d;
  state_t           state_q, state_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 20'd1;
      end
    end
  end

  // Opposing buttons on one axis cancel; the two axes are masked independently.
  always_comb begin
    active_d      = stable_q[3:0];
    if (stable_q[1:0] == 2'b11) active_d[1:0] = 2'b00;
    if (stable_q[3:2] == 2'b11) active_d[3:2] = 2'b00;
  end

  always_comb begin
    step_d = step_q;
    if (spd_p1_q && !spd_p2_q) begin
      step_d = (step_q == STEP_MAX) ? 4'd1 : step_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    pulse_d = 4'd0;
`ifdef AUTOREPEAT_EN
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (active_q != 4'd0) begin
          pulse_d = active_q;
          held_d  = active_q;
          timer_d = '0;
          state_d = S_FIRST;
        end
      end
      S_FIRST, S_REPEAT: begin
        if (active_q == 4'd0) begin
          state_d = S_IDLE;
        end else if (active_q != held_q) begin
          pulse_d = active_q;
          held_d  = active_q;
          timer_d = '0;
          state_d = S_FIRST;
        end else if ((state_q == S_FIRST  && timer_q == DELAY_LAST) ||
                     (state_q == S_REPEAT && timer_q == PERIOD_LAST)) begin
          pulse_d = active_q;
          timer_d = '0;
          state_d = S_REPEAT;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
`else
    case (state_q)
      S_IDLE: begin
        if (active_q != 4'd0) begin
          pulse_d = active_q;
          held_d  = active_q;
          state_d = S_HELD;
        end
      end
      S_HELD: begin
        if (active_q == 4'd0) begin
          state_d = S_IDLE;
        end else if (active_q != held_q) begin
          pulse_d = active_q;
          held_d  = active_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      spd_p1_q <= 1'b0;
      spd_p2_q <= 1'b0;
      step_q   <= 4'd1;
      held_q   <= '0;
      pulse_q  <= '0;
      state_q  <= S_IDLE;
`ifdef AUTOREPEAT_EN
      timer_q  <= '0;
`endif
    end else begin
      sync1_q  <= {buttonSpeed, buttonDir};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      spd_p1_q <= stable_q[4];
      spd_p2_q <= spd_p1_q;
      step_q   <= step_d;
      held_q   <= held_d;
      pulse_q  <= pulse_d;
      state_q  <= state_d;
`ifdef AUTOREPEAT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign moveDirection = pulse_q;
  assign moveStep      = step_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_move_command_gen.sv
// Bench for move_command_gen: directed table, corner sequences and random stimulus,
// all checked every cycle against a timing-rule reference model.
module tb_move_command_gen;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int MS = 4;
`ifdef AUTOREPEAT_EN
  localparam int UP36_PULSES = 3;
  localparam int SEQB_PULSES = 5;
`else
  localparam int UP36_PULSES = 1;
  localparam int SEQB_PULSES = 2;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] dir_in = 4'd0;
  logic       spd_in = 1'b0;
  logic [3:0] move_dir, move_step;
  logic [1:0] dbg_state;

  move_command_gen #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .MAX_STEP(MS)
  ) dut (
    .clock(clk), .reset(rst), .buttonDir(dir_in), .buttonSpeed(spd_in),
    .moveDirection(move_dir), .moveStep(move_step), .dbg_state_o(dbg_state)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int base    = 0;
  int pulse_cnt;
  logic [3:0]  last_vec;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // reference model: sync = raw one edge late; a level is accepted once D consecutive
  // synced samples disagree with it; outputs react two edges after the accepted level.
  logic [4:0] sync_hist[$];
  logic [4:0] stab_hist[$];
  logic [4:0] m_stable, m_prev_raw;
  logic [3:0] m_last;
  bit         m_idle;
  int         m_t0;
  logic [3:0] exp_dir, exp_step;

  function automatic logic [3:0] axis_mask(input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (v[0] && v[1]) r[1:0] = 2'b00;
    if (v[2] && v[3]) r[3:2] = 2'b00;
    return r;
  endfunction

  task automatic model_edge();
    logic [4:0] nxt;
    logic [3:0] act;
    bit all_diff;
    int dt;
    if (rst) begin
      sync_hist.delete();
      stab_hist.delete();
      repeat (3) stab_hist.push_back(5'd0);
      m_stable = 5'd0; m_prev_raw = 5'd0; m_idle = 1'b1; m_last = 4'd0;
      m_t0 = 0; exp_dir = 4'd0; exp_step = 4'd1;
      return;
    end
    nxt = m_stable;
    if (sync_hist.size() >= D) begin
      for (int i = 0; i < 5; i++) begin
        all_diff = 1'b1;
        for (int j = sync_hist.size() - D; j < sync_hist.size(); j++)
          if (sync_hist[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) nxt[i] = ~m_stable[i];
      end
    end
    sync_hist.push_back(m_prev_raw);
    if (sync_hist.size() > D) void'(sync_hist.pop_front());
    m_prev_raw = {spd_in, dir_in};

    act = axis_mask(stab_hist[1][3:0]);
    exp_dir = 4'd0;
    if (act == 4'd0) begin
      m_idle = 1'b1;
    end else if (m_idle || act != m_last) begin
      exp_dir = act; m_idle = 1'b0; m_last = act; m_t0 = cyc;
    end else begin
      dt = cyc - m_t0;
`ifdef AUTOREPEAT_EN
      if (dt == RD || (dt > RD && (dt - RD) % RP == 0)) exp_dir = act;
`endif
    end
    if (stab_hist[1][4] && !stab_hist[0][4])
      exp_step = (exp_step == 4'(MS)) ? 4'd1 : exp_step + 4'd1;

    stab_hist.push_back(nxt);
    void'(stab_hist.pop_front());
    m_stable = nxt;
  endtask

  // driver: one clock edge, model update, compare on the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk($sformatf("cyc%0d_dir", cyc), 32'(move_dir), 32'(exp_dir));
    chk($sformatf("cyc%0d_step", cyc), 32'(move_step), 32'(exp_step));
    if (move_dir != 4'd0) begin
      pulse_cnt++;
      last_vec = move_dir;
      obs_q.push_back({12'(cyc - base), move_dir});
    end
    cyc++;
  endtask

  typedef struct {
    logic [3:0] dir;
    logic       spd;
    int         press;
    int         idle;
    int         exp_pulses;
    logic [3:0] exp_vec;
    logic [3:0] exp_step;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{4'b0001, 1'b0, 36, 10, UP36_PULSES, 4'b0001, 4'd1};
    tbl[1]  = '{4'b0100, 1'b0,  3, 10, 0,           4'b0000, 4'd1};
    tbl[2]  = '{4'b0100, 1'b0,  6, 10, 1,           4'b0100, 4'd1};
    tbl[3]  = '{4'b0011, 1'b0, 30, 10, 0,           4'b0000, 4'd1};
    tbl[4]  = '{4'b0101, 1'b0, 10, 10, 1,           4'b0101, 4'd1};
    tbl[5]  = '{4'b0000, 1'b1,  6, 10, 0,           4'b0000, 4'd2};
    tbl[6]  = '{4'b0000, 1'b1,  6, 10, 0,           4'b0000, 4'd3};
    tbl[7]  = '{4'b0000, 1'b1,  6, 10, 0,           4'b0000, 4'd4};
    tbl[8]  = '{4'b0000, 1'b1,  6, 10, 0,           4'b0000, 4'd1};
    tbl[9]  = '{4'b0000, 1'b1,  6, 10, 0,           4'b0000, 4'd2};
    tbl[10] = '{4'b0000, 1'b1, 40, 10, 0,           4'b0000, 4'd3};
    tbl[11] = '{4'b0010, 1'b0, 10,  7, 1,           4'b0010, 4'd3};
    tbl[12] = '{4'b0010, 1'b0, 10, 10, 1,           4'b0010, 4'd3};

    rst = 1'b1;
    repeat (3) tick();
    chk("reset_dir", 32'(move_dir), 32'd0);
    chk("reset_step", 32'(move_step), 32'd1);
    rst = 1'b0;

    for (int k = 0; k < 13; k++) begin
      pulse_cnt = 0;
      last_vec  = 4'd0;
      dir_in = tbl[k].dir;
      spd_in = tbl[k].spd;
      repeat (tbl[k].press) tick();
      dir_in = 4'd0;
      spd_in = 1'b0;
      repeat (tbl[k].idle) tick();
      chk($sformatf("vec%0d_pulses", k), 32'(pulse_cnt), 32'(tbl[k].exp_pulses));
      if (tbl[k].exp_pulses != 0)
        chk($sformatf("vec%0d_last", k), 32'(last_vec), 32'(tbl[k].exp_vec));
      chk($sformatf("vec%0d_step", k), 32'(move_step), 32'(tbl[k].exp_step));
    end

    // Up+Left, then Up only: immediate new pulse and the first-repeat timer restarts
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back({12'd7, 4'b0101});
    exp_q.push_back({12'd17, 4'b0001});
`ifdef AUTOREPEAT_EN
    exp_q.push_back({12'd37, 4'b0001});
    exp_q.push_back({12'd45, 4'b0001});
    exp_q.push_back({12'd53, 4'b0001});
`endif
    base = cyc;
    dir_in = 4'b0101;
    repeat (10) tick();
    dir_in = 4'b0001;
    repeat (40) tick();
    dir_in = 4'b0000;
    repeat (12) tick();
    chk("seqb_count", 32'(obs_q.size()), 32'(SEQB_PULSES));
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      logic [15:0] o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hffff;
      chk("seqb_pulse", 32'(o), 32'(e));
    end

    // reset while Right is held in the repeat phase
    dir_in = 4'b1000;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_dir", 32'(move_dir), 32'd0);
    chk("rst_mid_step", 32'(move_step), 32'd1);
    rst = 1'b0;
    obs_q.delete();
    base = cyc;
    repeat (20) tick();
    if (obs_q.size() > 0) chk("rst_repress_pulse", 32'(obs_q[0]), 32'({12'd7, 4'b1000}));
    else chk("rst_repress_seen", 32'(obs_q.size()), 32'd1);
    dir_in = 4'b0000;
    repeat (12) tick();

    // random stimulus against the model
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b0;
      end
      dir_in = 4'($urandom_range(0, 15));
      spd_in = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 40)) tick();
    end
    dir_in = 4'd0;
    spd_in = 1'b0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
